// File: rtl/soric_inter_pkg.sv
// Shared types for the SoRIC interconnect arbiters: FSM state encoding and
// the select-width helper used to size owner/pointer indices.
package soric_inter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } arb_state_e;

   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first set request bit scanning
// ptr, ptr+1, ... modulo NUM_PORTS.
module rr_pick #(
   parameter int NUM_PORTS = 4,
   parameter int SEL_WIDTH = 2
) (
   input  logic [NUM_PORTS-1:0] request,
   input  logic [SEL_WIDTH-1:0] ptr,
   output logic                 valid,
   output logic [SEL_WIDTH-1:0] index
);

   function automatic logic [SEL_WIDTH-1:0] rot_idx(input logic [SEL_WIDTH-1:0] p, input int off);
      int s;
      s = int'(p) + off;
      if (s >= NUM_PORTS) s = s - NUM_PORTS;
      return SEL_WIDTH'(s);
   endfunction

   // Scan from the far end so the closest candidate to ptr is written last.
   always_comb begin
      valid = 1'b0;
      index = ptr;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (request[rot_idx(ptr, i)]) begin
            valid = 1'b1;
            index = rot_idx(ptr, i);
         end
      end
   end

endmodule

// File: rtl/txn_arbiter.sv
// Transaction-holding round-robin arbiter for one SRAM-style slave port.
// Optional response watchdog enabled by defining TXN_ARB_TIMEOUT_EN.
module txn_arbiter
   import soric_inter_pkg::*;
#(
   parameter int NUM_PORTS      = 4,
   parameter int SEL_WIDTH      = sel_width(NUM_PORTS),
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TO_WIDTH       = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_PORTS-1:0] request_i,
   input  logic                 slave_gnt_i,
   input  logic                 slave_rvalid_i,
   output logic [NUM_PORTS-1:0] grant_o,
   output logic [SEL_WIDTH-1:0] select_o,
   output logic                 active_o,
   output logic                 timeout_o
);

   if (NUM_PORTS < 2 || TIMEOUT_CYCLES >= (1 << TO_WIDTH)) begin : g_bad_cfg
      $error("txn_arbiter: unsupported NUM_PORTS / TIMEOUT_CYCLES / TO_WIDTH combination");
   end

   arb_state_e           state_q, state_d;
   logic [SEL_WIDTH-1:0] owner_q, owner_d;
   logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
   logic [SEL_WIDTH-1:0] next_ptr;
   logic [SEL_WIDTH-1:0] pick_ptr;
   logic [SEL_WIDTH-1:0] pick_index;
   logic                 pick_valid;
   logic                 timeout_hit;

   assign next_ptr = (owner_q == SEL_WIDTH'(NUM_PORTS - 1)) ? '0 : owner_q + SEL_WIDTH'(1);

   // One picker serves both the idle pick and the release re-pick.
   assign pick_ptr = (state_q == ST_IDLE) ? ptr_q : next_ptr;

   rr_pick #(
      .NUM_PORTS(NUM_PORTS),
      .SEL_WIDTH(SEL_WIDTH)
   ) u_pick (
      .request(request_i),
      .ptr    (pick_ptr),
      .valid  (pick_valid),
      .index  (pick_index)
   );

`ifdef TXN_ARB_TIMEOUT_EN
   logic [TO_WIDTH-1:0] wdog_q, wdog_d;

   assign timeout_hit = (state_q == ST_RESP) && (wdog_q == TO_WIDTH'(TIMEOUT_CYCLES));
   assign timeout_o   = timeout_hit;
`else
   assign timeout_hit = 1'b0;
   assign timeout_o   = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
`ifdef TXN_ARB_TIMEOUT_EN
      wdog_d  = wdog_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               owner_d = pick_index;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (!request_i[owner_q]) begin
               ptr_d   = next_ptr;
               owner_d = pick_valid ? pick_index : owner_q;
               state_d = pick_valid ? ST_REQ : ST_IDLE;
            end else if (slave_gnt_i) begin
               state_d = ST_RESP;
`ifdef TXN_ARB_TIMEOUT_EN
               wdog_d  = '0;
`endif
            end
         end
         ST_RESP: begin
            if (slave_rvalid_i || timeout_hit) begin
               ptr_d   = next_ptr;
               owner_d = pick_valid ? pick_index : owner_q;
               state_d = pick_valid ? ST_REQ : ST_IDLE;
            end else begin
`ifdef TXN_ARB_TIMEOUT_EN
               wdog_d = wdog_q + TO_WIDTH'(1);
`endif
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
      end
   end

`ifdef TXN_ARB_TIMEOUT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) wdog_q <= '0;
      else       wdog_q <= wdog_d;
   end
`endif

   // Outputs decode registered state only, so reset clears the grant at once.
   always_comb begin
      grant_o = '0;
      if (state_q != ST_IDLE) grant_o[owner_q] = 1'b1;
   end

   assign select_o = owner_q;
   assign active_o = |grant_o;

endmodule

// File: tb/tb_txn_arbiter.sv
// Self-checking bench for txn_arbiter: transaction-level reference model,
// per-cycle compare process, directed literal checks and random traffic.
module tb_txn_arbiter;

   localparam int N  = 4;
   localparam int TO = 10;
`ifdef TXN_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] request_i = '0;
   logic       slave_gnt_i = 1'b0;
   logic       slave_rvalid_i = 1'b0;
   logic [3:0] grant_o;
   logic [1:0] select_o;
   logic       active_o;
   logic       timeout_o;

   always #5 clk = ~clk;

   txn_arbiter #(
      .NUM_PORTS     (N),
      .SEL_WIDTH     (2),
      .TIMEOUT_CYCLES(TO),
      .TO_WIDTH      (8)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .request_i     (request_i),
      .slave_gnt_i   (slave_gnt_i),
      .slave_rvalid_i(slave_rvalid_i),
      .grant_o       (grant_o),
      .select_o      (select_o),
      .active_o      (active_o),
      .timeout_o     (timeout_o)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: who owns the slave, whether its transaction was accepted,
   // where the next round-robin scan starts, and how long we have waited.
   int m_owner  = -1;
   int m_last   = 0;
   int m_ptr    = 0;
   int m_waited = 0;
   bit m_resp   = 1'b0;

   function automatic int pick(input logic [3:0] r, input int p);
      for (int i = 0; i < N; i++) begin
         if (r[(p + i) % N]) return (p + i) % N;
      end
      return -1;
   endfunction

   function automatic logic [3:0] exp_grant();
      logic [3:0] g;
      g = '0;
      if (m_owner >= 0) g[m_owner] = 1'b1;
      return g;
   endfunction

   function automatic logic exp_timeout();
      return TO_EN && (m_owner >= 0) && m_resp && (m_waited == TO);
   endfunction

   task automatic model_release();
      m_ptr   = (m_owner + 1) % N;
      m_owner = pick(request_i, m_ptr);
      if (m_owner >= 0) begin
         m_last = m_owner;
         m_resp = 1'b0;
      end
   endtask

   task automatic model_step();
      if (m_owner < 0) begin
         m_owner = pick(request_i, m_ptr);
         if (m_owner >= 0) begin
            m_last = m_owner;
            m_resp = 1'b0;
         end
      end else if (!m_resp) begin
         if (!request_i[m_owner]) model_release();
         else if (slave_gnt_i) begin
            m_resp   = 1'b1;
            m_waited = 0;
         end
      end else begin
         if (slave_rvalid_i || exp_timeout()) model_release();
         else m_waited++;
      end
   endtask

   task automatic model_reset();
      m_owner  = -1;
      m_last   = 0;
      m_ptr    = 0;
      m_waited = 0;
      m_resp   = 1'b0;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (!reset) begin
         check("cmp_grant", 32'(grant_o), 32'(exp_grant()));
         check("cmp_select", 32'(select_o), 32'(m_last));
         check("cmp_active", 32'(active_o), 32'(m_owner >= 0));
         check("cmp_timeout", 32'(timeout_o), 32'(exp_timeout()));
      end
   end

   task automatic cyc(input logic [3:0] r, input logic g, input logic v);
      request_i      = r;
      slave_gnt_i    = g;
      slave_rvalid_i = v;
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic drain();
      for (int i = 0; i < 3; i++) cyc(4'b0000, 1'b0, 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      logic [3:0] r;
      #1 reset = 1'b1;
      #2;
      check("rst_grant", 32'(grant_o), 32'h0);
      check("rst_select", 32'(select_o), 32'h0);
      check("rst_active", 32'(active_o), 32'h0);
      check("rst_timeout", 32'(timeout_o), 32'h0);
      @(negedge clk);
      reset = 1'b0;

      // Round-robin with minimum-length transactions: new owner every 2 cycles.
      for (int k = 0; k < 10; k++) begin
         cyc(4'b1111, 1'b1, 1'b1);
         check("rr_grant", 32'(grant_o), 32'(1 << ((k / 2) % 4)));
         check("rr_select", 32'(select_o), 32'((k / 2) % 4));
      end
      drain();

      // Hold until response while another master toggles its request.
      cyc(4'b0010, 1'b0, 1'b0);
      check("hold_first", 32'(grant_o), 32'h2);
      cyc(4'b0010, 1'b0, 1'b0);
      cyc(4'b1010, 1'b1, 1'b0);
      for (int t = 0; t < 6; t++) begin
         cyc({t[0], 3'b010}, 1'b0, 1'b0);
         check("hold_grant", 32'(grant_o), 32'h2);
      end
      cyc(4'b1010, 1'b0, 1'b1);
      check("hold_next", 32'(grant_o), 32'h8);
      drain();

      // Asynchronous reset in the middle of a response.
      cyc(4'b0010, 1'b0, 1'b0);
      cyc(4'b0010, 1'b1, 1'b0);
      check("pre_rst_grant", 32'(grant_o), 32'h2);
      #2 reset = 1'b1;
      #1;
      check("async_rst_grant", 32'(grant_o), 32'h0);
      check("async_rst_active", 32'(active_o), 32'h0);
      model_reset();
      @(negedge clk);
      #2 reset = 1'b0;
      cyc(4'b0100, 1'b0, 1'b0);
      check("post_rst_grant", 32'(grant_o), 32'h4);
      check("post_rst_select", 32'(select_o), 32'h2);

      // Owner 2 withdraws: pointer wraps to 0 and master 0 wins.
      cyc(4'b0001, 1'b0, 1'b0);
      check("withdraw_grant", 32'(grant_o), 32'h1);
      check("withdraw_select", 32'(select_o), 32'h0);

      // Stray responses in REQ and IDLE change nothing.
      cyc(4'b0001, 1'b0, 1'b1);
      check("stray_req_grant", 32'(grant_o), 32'h1);
      drain();
      cyc(4'b0000, 1'b0, 1'b1);
      check("stray_idle_grant", 32'(grant_o), 32'h0);
      check("stray_idle_active", 32'(active_o), 32'h0);
      check("stray_idle_select", 32'(select_o), 32'h0);

      // Response never arrives.
      cyc(4'b0100, 1'b0, 1'b0);
      cyc(4'b0100, 1'b1, 1'b0);
`ifdef TXN_ARB_TIMEOUT_EN
      for (int t = 1; t <= 11; t++) begin
         cyc(4'b0001, 1'b0, 1'b0);
         check("to_pulse", 32'(timeout_o), 32'(t == 10));
         check("to_grant", 32'(grant_o), (t <= 10) ? 32'h4 : 32'h1);
      end
`else
      for (int t = 1; t <= 15; t++) begin
         cyc(4'b0001, 1'b0, 1'b0);
         check("wait_grant", 32'(grant_o), 32'h4);
         check("wait_timeout", 32'(timeout_o), 32'h0);
      end
`endif
      drain();

      // Random traffic against the model.
      r = 4'b0000;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) < 30) r = 4'($urandom_range(0, 15));
         cyc(r, 1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 99) < 30));
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
